// File: rtl/rs_pkg.sv
// Shared Reed-Solomon definitions: code geometry, GF(2^10) arithmetic,
// generator polynomial and the encoder FSM state type.
package rs_pkg;

    localparam int unsigned SYM_W     = 10;
    localparam int unsigned N         = 528;
    localparam int unsigned K         = 514;
    localparam int unsigned T         = (N - K) / 2;
    localparam int unsigned NPAR      = 2 * T;
    localparam logic [SYM_W:0] PRIM_POLY = 11'h409;

    typedef logic [SYM_W-1:0]            sym_t;
    typedef logic [NPAR-1:0][SYM_W-1:0]  gen_t;

    typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

    // Shift-and-reduce multiply modulo PRIM_POLY.
    function automatic sym_t gf_mul(input sym_t a, input sym_t b);
        sym_t acc;
        sym_t sh;
        acc = '0;
        sh  = a;
        for (int unsigned i = 0; i < SYM_W; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[SYM_W-2:0], 1'b0} ^ (sh[SYM_W-1] ? PRIM_POLY[SYM_W-1:0] : '0);
        end
        return acc;
    endfunction

    // g(x) = prod_{j=0}^{2T-1} (x + alpha^j); the monic x^2T term is implicit.
    function automatic gen_t gen_poly();
        sym_t c [0:NPAR];
        sym_t root;
        gen_t g;
        for (int unsigned i = 0; i <= NPAR; i++) c[i] = '0;
        c[0] = sym_t'(1);
        root = sym_t'(1);
        for (int unsigned j = 0; j < NPAR; j++) begin
            for (int unsigned i = NPAR; i >= 1; i--) c[i] = c[i-1] ^ gf_mul(c[i], root);
            c[0] = gf_mul(c[0], root);
            root = gf_mul(root, sym_t'(2));
        end
        for (int unsigned i = 0; i < NPAR; i++) g[i] = c[i];
        return g;
    endfunction

    localparam gen_t G = gen_poly();

endpackage

// File: rtl/rs_enc_lfsr.sv
// Parity register bank: LFSR division of the message by g(x), then drain.
module rs_enc_lfsr
    import rs_pkg::*;
(
    input  logic clk,
    input  logic rstn,
    input  logic clr_i,
    input  logic load_i,
    input  logic shift_i,
    input  sym_t din_i,
    output sym_t par_o
);

    gen_t r_q;
    gen_t r_d;
    sym_t fb;

    assign fb    = din_i ^ r_q[NPAR-1];
    assign par_o = r_q[NPAR-1];

    // Clear wins; load folds a message symbol in; shift drains parity highest-degree first.
    always_comb begin
        r_d = r_q;
        if (clr_i) begin
            r_d = '0;
        end else if (load_i) begin
            r_d[0] = gf_mul(G[0], fb);
            for (int unsigned i = 1; i < NPAR; i++) r_d[i] = r_q[i-1] ^ gf_mul(G[i], fb);
        end else if (shift_i) begin
            r_d[0] = '0;
            for (int unsigned i = 1; i < NPAR; i++) r_d[i] = r_q[i-1];
        end
    end

    // Register bank state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_q <= '0;
        else       r_q <= r_d;
    end

endmodule

// File: rtl/rs_enc.sv
// Systematic RS(528,514) encoder: forwards K message symbols, then appends 2T parity.
module rs_enc
    import rs_pkg::*;
#(
    parameter int unsigned MSG_LEN = K
)
(
    input  logic clk,
    input  logic rstn,
    input  logic rs_ena,
    input  logic tx_vld,
    input  sym_t tx_data,
    input  logic tx_isos,
    output logic tx_rdy,
    output logic enc_vld,
    output sym_t enc_data,
    output logic enc_isos,
    output logic enc_sof,
    output logic enc_eof,
    output logic ENC_ERROR
);

    localparam int unsigned CNT_W = $clog2(MSG_LEN + 1);
    localparam int unsigned PAR_W = $clog2(NPAR);
    localparam logic [CNT_W-1:0] LAST_MSG = CNT_W'(MSG_LEN - 1);
    localparam logic [PAR_W-1:0] LAST_PAR = PAR_W'(NPAR - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] msg_cnt_q, msg_cnt_d;
    logic [PAR_W-1:0] par_cnt_q, par_cnt_d;
    logic             vld_q, vld_d;
    sym_t             data_q, data_d;
    logic             isos_q, isos_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             err_q, err_d;
    logic             accept;
    logic             lfsr_shift;
    sym_t             par_sym;

    assign tx_rdy = rs_ena & (state_q != PAR);
    assign accept = tx_vld & tx_rdy;
    assign err_d  = tx_vld & ~tx_rdy & rs_ena;

    rs_enc_lfsr u_lfsr (
        .clk     (clk),
        .rstn    (rstn),
        .clr_i   (~rs_ena),
        .load_i  (accept),
        .shift_i (lfsr_shift),
        .din_i   (tx_data),
        .par_o   (par_sym)
    );

    // Next state, counters and the registered output symbol.
    always_comb begin
        state_d    = state_q;
        msg_cnt_d  = msg_cnt_q;
        par_cnt_d  = par_cnt_q;
        vld_d      = 1'b0;
        data_d     = '0;
        isos_d     = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        lfsr_shift = 1'b0;
        if (!rs_ena) begin
            state_d   = IDLE;
            msg_cnt_d = '0;
            par_cnt_d = '0;
        end else begin
            unique case (state_q)
                IDLE, MSG: begin
                    if (accept) begin
                        vld_d     = 1'b1;
                        data_d    = tx_data;
                        isos_d    = tx_isos;
                        sof_d     = (state_q == IDLE);
                        msg_cnt_d = msg_cnt_q + CNT_W'(1);
                        par_cnt_d = '0;
                        state_d   = (msg_cnt_q == LAST_MSG) ? PAR : MSG;
                    end
                end
                PAR: begin
                    vld_d      = 1'b1;
                    data_d     = par_sym;
                    lfsr_shift = 1'b1;
                    if (par_cnt_q == LAST_PAR) begin
                        eof_d     = 1'b1;
                        state_d   = IDLE;
                        msg_cnt_d = '0;
                        par_cnt_d = '0;
                    end else begin
                        par_cnt_d = par_cnt_q + PAR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            msg_cnt_q <= '0;
            par_cnt_q <= '0;
            vld_q     <= 1'b0;
            data_q    <= '0;
            isos_q    <= 1'b0;
            sof_q     <= 1'b0;
            eof_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_cnt_q <= msg_cnt_d;
            par_cnt_q <= par_cnt_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
            isos_q    <= isos_d;
            sof_q     <= sof_d;
            eof_q     <= eof_d;
            err_q     <= err_d;
        end
    end

    assign enc_vld   = vld_q;
    assign enc_data  = data_q;
    assign enc_isos  = isos_q;
    assign enc_sof   = sof_q;
    assign enc_eof   = eof_q;
    assign ENC_ERROR = err_q;

endmodule

// File: tb/tb_rs_enc.sv
// Testbench for rs_enc: cycle-vector table for control corners, then full codewords
// checked against a long-division reference and codeword syndromes.
module tb_rs_enc;
    import rs_pkg::K;
    import rs_pkg::N;
    import rs_pkg::NPAR;
    import rs_pkg::sym_t;

    localparam int unsigned CAP = 4096;

    logic clk = 1'b0;
    logic rstn, rs_ena, tx_vld, tx_isos;
    sym_t tx_data;
    logic tx_rdy, enc_vld, enc_isos, enc_sof, enc_eof, ENC_ERROR;
    sym_t enc_data;

    rs_enc dut (
        .clk       (clk),
        .rstn      (rstn),
        .rs_ena    (rs_ena),
        .tx_vld    (tx_vld),
        .tx_data   (tx_data),
        .tx_isos   (tx_isos),
        .tx_rdy    (tx_rdy),
        .enc_vld   (enc_vld),
        .enc_data  (enc_data),
        .enc_isos  (enc_isos),
        .enc_sof   (enc_sof),
        .enc_eof   (enc_eof),
        .ENC_ERROR (ENC_ERROR)
    );

    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    sym_t        cap_data [0:CAP-1];
    logic        cap_iso  [0:CAP-1];
    logic        cap_sof  [0:CAP-1];
    logic        cap_eof  [0:CAP-1];
    int unsigned cap_n = 0, cyc = 0, err_n = 0, rdy_low = 0, run_len = 0, eof_run = 0;
    int unsigned last_sof = 0, prev_sof = 0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rstn) begin
            if (enc_vld && cap_n < CAP) begin
                cap_data[cap_n] <= enc_data;
                cap_iso[cap_n]  <= enc_isos;
                cap_sof[cap_n]  <= enc_sof;
                cap_eof[cap_n]  <= enc_eof;
                cap_n           <= cap_n + 1;
            end
            run_len <= enc_vld ? run_len + 1 : 0;
            if (enc_vld && enc_eof) eof_run <= run_len + 1;
            if (enc_vld && enc_sof) begin
                prev_sof <= last_sof;
                last_sof <= cyc;
            end
            if (ENC_ERROR) err_n <= err_n + 1;
            if (rs_ena && !tx_rdy) rdy_low <= rdy_low + 1;
        end
    end

    // ---------------- reference GF model ----------------
    int unsigned ex [0:1023];
    int unsigned lg [0:1023];
    sym_t        gb [0:NPAR];
    sym_t        msg   [0:1][0:K-1];
    logic        iso_m [0:1][0:K-1];
    sym_t        cw    [0:1][0:N-1];

    int unsigned n_cmp = 0, n_bad = 0;

    function automatic sym_t gmul(input sym_t a, input sym_t b);
        if (a == 0 || b == 0) return '0;
        return sym_t'(ex[(lg[a] + lg[b]) % 1023]);
    endfunction

    task automatic build_gf();
        int unsigned e;
        e = 1;
        for (int i = 0; i < 1023; i++) begin
            ex[i] = e;
            lg[e] = i;
            e = e << 1;
            if ((e & 1024) != 0) e = e ^ 32'h409;
        end
        for (int i = 0; i <= NPAR; i++) gb[i] = '0;
        gb[0] = 10'd1;
        for (int j = 0; j < NPAR; j++) begin
            for (int i = NPAR; i >= 1; i--) gb[i] = gb[i-1] ^ gmul(gb[i], sym_t'(ex[j]));
            gb[0] = gmul(gb[0], sym_t'(ex[j]));
        end
    endtask

    // Textbook long division of m(x)*x^2T by g(x); index 0 is the highest degree.
    task automatic ref_encode(input int s);
        sym_t d [0:N-1];
        sym_t coef;
        for (int j = 0; j < N; j++) d[j] = (j < K) ? msg[s][j] : '0;
        for (int i = 0; i < K; i++) begin
            coef = d[i];
            if (coef != 0)
                for (int j = 1; j <= NPAR; j++) d[i+j] = d[i+j] ^ gmul(coef, gb[NPAR-j]);
        end
        for (int j = 0; j < N; j++) cw[s][j] = (j < K) ? msg[s][j] : d[j];
    endtask

    task automatic check(input string nm, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, req);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic ena, input logic vld, input sym_t d, input logic iso,
                         output logic acc);
        @(posedge clk);
        #2;
        rs_ena  = ena;
        tx_vld  = vld;
        tx_data = d;
        tx_isos = iso;
        #1;
        acc = ena & vld & tx_rdy;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, 1'b0, acc);
    endtask

    task automatic send_msg(input int s, input int nsym, input int gap_pct, input bit hold_par,
                            input string nm);
        logic acc;
        int   i, budget;
        i = 0;
        budget = 0;
        while (i < nsym && budget < 4 * N) begin
            if (gap_pct != 0 && $urandom_range(99) < gap_pct) begin
                drive(1'b1, 1'b0, '0, 1'b0, acc);
            end else begin
                drive(1'b1, 1'b1, msg[s][i], iso_m[s][i], acc);
                if (acc) i++;
            end
            budget++;
        end
        check({nm, "_accepted"}, i, nsym);
        if (hold_par)
            for (int p = 0; p < NPAR; p++) drive(1'b1, 1'b1, 10'h3A5, 1'b1, acc);
    endtask

    task automatic check_cw(input int s, input int unsigned base, input string nm);
        int unsigned bd, bi, bs, be, bsyn;
        sym_t        sy;
        logic        ei;
        bd = 0; bi = 0; bs = 0; be = 0; bsyn = 0;
        if (cap_n < base + N) begin
            check({nm, "_len"}, cap_n - base, N);
            return;
        end
        for (int j = 0; j < N; j++) begin
            ei = (j < K) ? iso_m[s][j] : 1'b0;
            if (cap_data[base+j] != cw[s][j]) bd++;
            if (cap_iso[base+j] != ei) bi++;
            if (cap_sof[base+j] != (j == 0)) bs++;
            if (cap_eof[base+j] != (j == N - 1)) be++;
        end
        for (int r = 0; r < NPAR; r++) begin
            sy = '0;
            for (int j = 0; j < N; j++) sy = gmul(sy, sym_t'(ex[r])) ^ cap_data[base+j];
            if (sy != 0) bsyn++;
        end
        check({nm, "_data_errs"}, bd, 0);
        check({nm, "_isos_errs"}, bi, 0);
        check({nm, "_sof_errs"}, bs, 0);
        check({nm, "_eof_errs"}, be, 0);
        check({nm, "_nonzero_syndromes"}, bsyn, 0);
    endtask

    task automatic fill_random(input int s, input bit with_iso);
        for (int i = 0; i < K; i++) begin
            msg[s][i]   = sym_t'($urandom_range(1023));
            iso_m[s][i] = with_iso ? 1'($urandom_range(1)) : 1'b0;
        end
    endtask

    // ---------------- control-corner vector table ----------------
    typedef struct {
        logic ena, vld; sym_t data; logic iso;
        logic e_rdy, e_vld; sym_t e_data; logic e_sof, e_iso, e_err;
    } vec_t;
    vec_t vt [0:7];

    initial begin
        logic        acc;
        int unsigned base, rl0, e0, bad;

        rstn = 1'b0; rs_ena = 1'b1; tx_vld = 1'b0; tx_data = '0; tx_isos = 1'b0;
        build_gf();

        // inputs applied this cycle; outputs expected from the previous cycle's inputs
        vt[0] = '{1'b1, 1'b0, 10'h000, 1'b0,  1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b1, 10'h155, 1'b1,  1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vt[2] = '{1'b1, 1'b0, 10'h000, 1'b0,  1'b1, 1'b1, 10'h155, 1'b1, 1'b1, 1'b0};
        vt[3] = '{1'b1, 1'b1, 10'h2AA, 1'b0,  1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b0, 1'b1, 10'h3FF, 1'b1,  1'b0, 1'b1, 10'h2AA, 1'b0, 1'b0, 1'b0};
        vt[5] = '{1'b1, 1'b1, 10'h001, 1'b0,  1'b1, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};
        vt[6] = '{1'b1, 1'b0, 10'h000, 1'b0,  1'b1, 1'b1, 10'h001, 1'b1, 1'b0, 1'b0};
        vt[7] = '{1'b0, 1'b0, 10'h000, 1'b0,  1'b0, 1'b0, 10'h000, 1'b0, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_enc_vld", enc_vld, 0);
        check("rst_enc_data", enc_data, 0);
        check("rst_enc_sof", enc_sof, 0);
        check("rst_enc_eof", enc_eof, 0);
        check("rst_enc_err", ENC_ERROR, 0);
        check("rst_tx_rdy", tx_rdy, 1);
        @(posedge clk);
        #2 rstn = 1'b1;

        for (int r = 0; r < 8; r++) begin
            drive(vt[r].ena, vt[r].vld, vt[r].data, vt[r].iso, acc);
            @(negedge clk);
            check($sformatf("vec%0d_tx_rdy", r), tx_rdy, vt[r].e_rdy);
            check($sformatf("vec%0d_enc_vld", r), enc_vld, vt[r].e_vld);
            check($sformatf("vec%0d_enc_sof", r), enc_sof, vt[r].e_sof);
            check($sformatf("vec%0d_enc_err", r), ENC_ERROR, vt[r].e_err);
            if (vt[r].e_vld) begin
                check($sformatf("vec%0d_enc_data", r), enc_data, vt[r].e_data);
                check($sformatf("vec%0d_enc_isos", r), enc_isos, vt[r].e_iso);
            end
        end
        idle(3);

        // all-zero message at full rate
        for (int i = 0; i < K; i++) begin msg[0][i] = '0; iso_m[0][i] = 1'b0; end
        ref_encode(0);
        base = cap_n; rl0 = rdy_low;
        send_msg(0, K, 0, 1'b0, "zero");
        idle(20);
        check_cw(0, base, "zero");
        check("zero_count", cap_n - base, N);
        check("zero_rdy_low_cycles", rdy_low - rl0, NPAR);

        // impulse in the last message symbol: parity is g(x) itself
        msg[0][K-1] = 10'h001;
        ref_encode(0);
        base = cap_n;
        send_msg(0, K, 0, 1'b0, "impulse");
        idle(20);
        check_cw(0, base, "impulse");
        bad = 0;
        for (int j = 0; j < NPAR; j++)
            if (cap_data[base+K+j] != gb[NPAR-1-j]) bad++;
        check("impulse_parity_vs_g", bad, 0);

        // random message, random isos, ~30% input gaps
        fill_random(0, 1'b1);
        ref_encode(0);
        base = cap_n;
        send_msg(0, K, 30, 1'b0, "gaps");
        idle(20);
        check_cw(0, base, "gaps");
        check("gaps_count", cap_n - base, N);

        // two codewords back-to-back
        fill_random(0, 1'b1);
        fill_random(1, 1'b0);
        ref_encode(0);
        ref_encode(1);
        base = cap_n;
        send_msg(0, K, 0, 1'b0, "b2b0");
        send_msg(1, K, 0, 1'b0, "b2b1");
        idle(20);
        check_cw(0, base, "b2b0");
        check_cw(1, base + N, "b2b1");
        check("b2b_sof_spacing", last_sof - prev_sof, N);
        check("b2b_vld_run", eof_run, 2 * N);

        // tx_vld held during parity
        fill_random(0, 1'b0);
        ref_encode(0);
        base = cap_n; e0 = err_n;
        send_msg(0, K, 0, 1'b1, "hold");
        idle(20);
        check_cw(0, base, "hold");
        check("hold_err_pulses", err_n - e0, NPAR);
        check("hold_count", cap_n - base, N);

        // abort at msg_cnt=200, then a clean codeword
        fill_random(0, 1'b0);
        base = cap_n;
        send_msg(0, 200, 0, 1'b0, "abort");
        drive(1'b0, 1'b0, '0, 1'b0, acc);
        idle(20);
        check("abort_count", cap_n - base, 200);
        bad = 0;
        for (int unsigned j = base; j < cap_n; j++) if (cap_eof[j]) bad++;
        check("abort_eof_seen", bad, 0);
        fill_random(0, 1'b1);
        ref_encode(0);
        base = cap_n;
        send_msg(0, K, 0, 1'b0, "after_abort");
        idle(20);
        check_cw(0, base, "after_abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rs_enc.md
Name: rs_enc

Overview:
Systematic Reed-Solomon encoder. It is the transmit-side counterpart of the rs_dec receive path.
- Accepts K message symbols per codeword, forwards them unchanged, then appends 2T parity symbols.
- Parity is computed by an LFSR division by the generator polynomial over GF(2^SYM_W).
- Sits between the TX framing logic and the serializer.
- Its output stream is the codeword format rs_dec consumes on rx_vld/rx_data.

Parameters:
SYM_W, 10, symbol width in bits (equals `WIDTH)
N, 528, codeword length in symbols
K, 514, message length in symbols; 2T = N-K = 14 parity symbols
PRIM_POLY, 11'h409, primitive polynomial x^10+x^3+1

Ports:
clk  input  1  clock, all state on posedge
rstn  input  1  asynchronous active-low reset
rs_ena  input  1  encoder enable; low = synchronous abort/clear
tx_vld  input  1  message symbol valid
tx_data  input  SYM_W  message symbol
tx_isos  input  1  ordered-set marker, travels with the symbol
tx_rdy  output  1  encoder can accept a message symbol this cycle
enc_vld  output  1  output symbol valid
enc_data  output  SYM_W  codeword symbol (message, then parity)
enc_isos  output  1  tx_isos delayed to match enc_data; 0 on parity
enc_sof  output  1  first symbol of codeword
enc_eof  output  1  last parity symbol of codeword
ENC_ERROR  output  1  one-cycle pulse: tx_vld while tx_rdy=0 (symbol dropped)

Behaviour:
- Reset (rstn=0, async): state=IDLE, msg_cnt=0, par_cnt=0, LFSR=0. All outputs 0 except tx_rdy.
- tx_rdy is combinational from state. It is 1 in IDLE and MSG, 0 in PAR, and 0 whenever rs_ena=0.
- Accept = tx_vld & tx_rdy & rs_ena.
- LFSR on accept:
  - fb = tx_data ^ r[2T-1]
  - r[i] = r[i-1] ^ gf_mul(g[i], fb) for i = 2T-1..1
  - r[0] = gf_mul(g[0], fb)
  - g[] are the generator coefficients with implicit monic g[2T] = 1.
- Message output: enc_data = tx_data and enc_isos = tx_isos, registered, 1-cycle latency from accept.
- FSM:
  - IDLE -> MSG on accept. That symbol gets enc_sof=1; msg_cnt becomes 1.
  - MSG: each accept increments msg_cnt. When the accept makes msg_cnt=K, go to PAR with par_cnt=0.
  - PAR: one parity symbol per cycle, unconditionally.
    - enc_data = r[2T-1], enc_vld=1, enc_isos=0.
    - LFSR shifts: r[i] = r[i-1], r[0] = 0.
    - par_cnt increments. At par_cnt=2T-1, assert enc_eof, then go to IDLE and clear counters.
- Gaps: tx_vld=0 in MSG holds all state; enc_vld=0 that cycle.
- Throughput: back-to-back codewords with no bubbles.
  - K-th accept at cycle t gives message out at t+1 and parity at t+2..t+15.
  - tx_rdy is low for t+1..t+14.
  - The next codeword's first accept is possible at t+15; its enc_sof appears at t+16.
- ENC_ERROR pulses one cycle (registered) on tx_vld & !tx_rdy & rs_ena. The offered symbol is ignored, with no state change.
- rs_ena=0 mid-codeword: next edge returns to IDLE and clears LFSR/counters. No parity is emitted and enc_vld=0 thereafter. The partial codeword is discarded downstream.
- Async reset mid-codeword: same as reset; no partial output.
- K=1 boundary: the accept from IDLE goes directly to PAR. enc_sof and the message symbol are output together.

Decomposition:
- Package rs_pkg holds: SYM_W, N, K, T, PRIM_POLY, the typedef sym_t, the generator coefficient array G[0:2T-1], function gf_mul (shift-and-reduce), and the FSM state enum {IDLE, MSG, PAR}.
- rs_dec shares this package.
- Sub-module rs_enc_lfsr holds the parity register bank with load/shift/clear controls.
- FSM and counters live in rs_enc.

Test Plan:
- All-zero message, tx_vld continuous -> 514 zero symbols then 14 zero parity symbols. enc_sof on symbol 0, enc_eof on symbol 527, tx_rdy low exactly 14 cycles.
- Message zeros except last symbol = 10'h001 -> parity symbols equal G[13], G[12], ..., G[0] in emission order.
- Random message with random tx_vld gaps (~30%) -> enc_data matches a software RS(528,514) reference codeword. Feeding it into rs_dec gives RDE_ERROR=0 and dec_data equal to the message.
- Two codewords back-to-back at full rate -> 1056 consecutive enc_vld=1 cycles. Second enc_sof occurs exactly 528 cycles after the first.
- tx_vld held high during PAR -> ENC_ERROR pulses once per offending cycle and parity is unchanged vs the golden model.
- rs_ena dropped at msg_cnt=200, then re-raised -> no parity emitted. The next codeword starts with enc_sof and its parity matches the golden model, with no carry-over.
